overdrive_multi: RTL and testbench
==================================

# overdrive_multi

Parametrised, multi-channel successor to the single-sample clipping overdrive stage. Accepts a frame of `CHANNELS` signed samples on a `START` pulse and processes them serially through one shared shaper datapath. The shaper applies a saturating pre-gain, then bypass, hard-clip or soft-knee shaping against a programmable symmetric threshold. It sits in the effects chain between the audio frame source and the next pedal stage, using the same `START`/`DONE` pulse handshake.

## Interface
- `DATA_W`, default 16: sample width, signed two's complement.
- `CHANNELS`, default 2: samples per frame; must be ≥ 1.
- `KNEE_SHIFT`, default 2: soft-mode attenuation of excess above threshold, as an arithmetic right shift.

- `CLK` in 1: single clock; all logic on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `START` in 1: request to process a frame; sampled only in IDLE.
- `BUSY` out 1: high whenever the state is not IDLE.
- `DONE` out 1: one-cycle pulse; `output_frame` is valid from this cycle on.
- `mode` in 2: 0 bypass, 1 hard clip, 2 soft knee, 3 treated as hard clip.
- `pre_gain` in 2: left-shift amount 0..3 applied before shaping.
- `threshold` in DATA_W-1: unsigned clip level T; effective bounds are ±T.
- `input_frame` in CHANNELS*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
- `output_frame` out CHANNELS*DATA_W: processed frame, same packing.

## Operation
- States: IDLE, RUN, FIN.
- IDLE → RUN on `START`=1. On the same edge, latch `input_frame`, `mode`, `pre_gain` and `threshold` into working registers and clear channel counter `ch` to 0.
- RUN: each cycle, shape latched sample `ch`, write the result into shadow slot `ch`, and increment `ch`. When `ch`=CHANNELS-1, the next state is FIN.
- FIN: copy the shadow frame to `output_frame`, assert `DONE` for this one cycle, return to IDLE.
- `START` in RUN or FIN is ignored; no queueing.
- Input ports may change freely after the accepting edge without affecting the result.
- `output_frame` changes only on entry to FIN and holds until the next FIN.
- Shaper, for a latched sample x with bypass mode:
  - Output is x unchanged; `pre_gain` is ignored.
- Shaper, for all other modes:
  - Gain: g = x <<< `pre_gain`, computed at DATA_W+3 bits, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Hard: clamp g to [-T, T], with T zero-extended. T=0 gives output 0.
  - Soft: if g > T, output T + ((g-T) >>> KNEE_SHIFT). If g < -T, output -T + ((g+T) >>> KNEE_SHIFT). Otherwise output g.
  - Soft arithmetic shift floors toward -∞. The result always fits in DATA_W; no further saturation is required.
- Clipping is symmetric (±T). Asymmetric bounds are not supported.

## Timing
- Reset values: state IDLE, `DONE`=0, `BUSY`=0, `output_frame`=0, `ch`=0, all working registers 0.
- Reset mid-RUN or in FIN aborts the frame. No `DONE` pulse is produced, `output_frame` returns to 0, and the next `START` after reset release is accepted normally.
- Latency: `START` sampled at edge e0 → `BUSY` high after e0 → `DONE` and new `output_frame` visible after edge e0+CHANNELS+1 → `DONE` and `BUSY` low after e0+CHANNELS+2.
- Throughput: the earliest next acceptance is at edge e0+CHANNELS+2, so the frame period is CHANNELS+2 cycles.
- `DONE` is never high for two consecutive cycles.
- Shaper is a combinational path from working registers to the shadow register; one channel per cycle.

## Structure
- Package `overdrive_pkg` contains:
  - enum `od_mode_e`: OD_BYPASS=0, OD_HARD=1, OD_SOFT=2, OD_RSVD=3.
  - enum `od_state_e`: IDLE, RUN, FIN.
- Sub-module `overdrive_shaper`: purely combinational, parametrised by DATA_W and KNEE_SHIFT. Inputs are x, mode, pre_gain and T; output is y. The top-level holds the FSM, counter, latches and shadow/output registers.

## Test plan
All scenarios use DATA_W=16, CHANNELS=2, KNEE_SHIFT=2.
- Hard clip: mode 1, gain 0, T=0x0FFF, in {0x7000, 0x9000} → out {0x0FFF, 0xF001}. `DONE` pulses exactly once, 3 edges after `START`.
- Gain saturation: mode 1, gain 3, T=0x7FFF, in {0x2000, 0xE000} → out {0x7FFF, 0x8001}.
- Soft knee: mode 2, gain 0, T=0x1000, in {0x3000, 0xD000} → out {0x1800, 0xE800}. Also in {0x0800, 0xF800} → unchanged.
- Bypass and isolation:
  - mode 0, gain 3, in {0x1234, 0x8000} → out identical.
  - Changing `input_frame` or `mode` one cycle after `START` does not alter the result.
- Handshake: `START` held high continuously → frames accepted every 4 cycles. `START` pulses during RUN/FIN produce no extra `DONE`.
- Reset: assert `RESET_N`=0 one cycle into RUN → `DONE` never pulses, `output_frame`=0, `BUSY`=0. A subsequent `START` completes correctly.

Source files
------------

// File: rtl/overdrive_pkg.sv
// Shared types for the multi-channel overdrive stage.
package overdrive_pkg;

  typedef enum logic [1:0] {
    OD_BYPASS = 2'd0,
    OD_HARD   = 2'd1,
    OD_SOFT   = 2'd2,
    OD_RSVD   = 2'd3
  } od_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } od_state_e;

endpackage

// File: rtl/overdrive_shaper.sv
// Combinational shaper: saturating pre-gain followed by bypass, hard clip
// or soft knee against a symmetric threshold +/-t.
module overdrive_shaper
  import overdrive_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int KNEE_SHIFT = 2
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic [1:0]               mode,
  input  logic [1:0]               pre_gain,
  input  logic [DATA_W-2:0]        t,
  output logic signed [DATA_W-1:0] y
);

  localparam int GW = DATA_W + 3;
  localparam logic signed [GW-1:0] MAX_V = {{4{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [GW-1:0] MIN_V = {{4{1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [GW-1:0] xe;
  logic signed [GW-1:0] gs;
  logic signed [GW-1:0] ge;
  logic signed [GW-1:0] te;
  logic signed [GW-1:0] excess;

  // Gain, saturation and shaping; all arithmetic at DATA_W+3 bits so the
  // shifted sample and the soft-knee sums never wrap before truncation.
  always_comb begin
    xe     = {{3{x[DATA_W-1]}}, x};
    gs     = xe <<< pre_gain;
    te     = {4'b0000, t};
    excess = '0;
    if (gs > MAX_V) begin
      ge = MAX_V;
    end else if (gs < MIN_V) begin
      ge = MIN_V;
    end else begin
      ge = gs;
    end
    y = DATA_W'(ge);
    case (od_mode_e'(mode))
      OD_BYPASS: y = x;
      OD_SOFT: begin
        if (ge > te) begin
          excess = (ge - te) >>> KNEE_SHIFT;
          y      = DATA_W'(te + excess);
        end else if (ge < -te) begin
          excess = (ge + te) >>> KNEE_SHIFT;
          y      = DATA_W'(excess - te);
        end
      end
      default: begin
        if (ge > te) begin
          y = DATA_W'(te);
        end else if (ge < -te) begin
          y = DATA_W'(-te);
        end
      end
    endcase
  end

endmodule

// File: rtl/overdrive_multi.sv
// Multi-channel overdrive: latches a frame on START, shapes one channel per
// cycle through a shared shaper, publishes the frame with a DONE pulse.
module overdrive_multi
  import overdrive_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int CHANNELS   = 2,
  parameter int KNEE_SHIFT = 2
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         START,
  output logic                         BUSY,
  output logic                         DONE,
  input  logic [1:0]                   mode,
  input  logic [1:0]                   pre_gain,
  input  logic [DATA_W-2:0]            threshold,
  input  logic [CHANNELS*DATA_W-1:0]   input_frame,
  output logic [CHANNELS*DATA_W-1:0]   output_frame
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  od_state_e                 state;
  od_state_e                 state_next;
  logic [CHANNELS*DATA_W-1:0] frame_q;
  logic [CHANNELS*DATA_W-1:0] shadow;
  logic [1:0]                mode_q;
  logic [1:0]                gain_q;
  logic [DATA_W-2:0]         thr_q;
  logic [CW-1:0]             ch;
  logic                      done_q;
  logic signed [DATA_W-1:0]  sample;
  logic signed [DATA_W-1:0]  shaped;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; START is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = RUN;
      RUN:     if (ch == LAST_CH) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. DONE is registered out of FIN, so BUSY is also held through
  // the DONE cycle to keep the frame period at CHANNELS+2.
  always_comb begin
    DONE = done_q;
    BUSY = (state != IDLE) || done_q;
  end

  assign sample = frame_q[ch*DATA_W +: DATA_W];

  overdrive_shaper #(
    .DATA_W     (DATA_W),
    .KNEE_SHIFT (KNEE_SHIFT)
  ) u_shaper (
    .x        (sample),
    .mode     (mode_q),
    .pre_gain (gain_q),
    .t        (thr_q),
    .y        (shaped)
  );

  // Working registers, channel counter, shadow and published frame.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_q      <= '0;
      mode_q       <= '0;
      gain_q       <= '0;
      thr_q        <= '0;
      ch           <= '0;
      shadow       <= '0;
      output_frame <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      case (state)
        IDLE: begin
          if (START) begin
            frame_q <= input_frame;
            mode_q  <= mode;
            gain_q  <= pre_gain;
            thr_q   <= threshold;
            ch      <= '0;
          end
        end
        RUN: begin
          shadow[ch*DATA_W +: DATA_W] <= shaped;
          ch <= (ch == LAST_CH) ? '0 : ch + CW'(1);
        end
        FIN: output_frame <= shadow;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_overdrive_multi.sv
// Directed bench for overdrive_multi (DATA_W=16, CHANNELS=2, KNEE_SHIFT=2).
module tb_overdrive_multi;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic        BUSY;
  logic        DONE;
  logic [1:0]  mode;
  logic [1:0]  pre_gain;
  logic [14:0] threshold;
  logic [31:0] input_frame;
  logic [31:0] output_frame;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  overdrive_multi #(
    .DATA_W     (16),
    .CHANNELS   (2),
    .KNEE_SHIFT (2)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .START        (START),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .mode         (mode),
    .pre_gain     (pre_gain),
    .threshold    (threshold),
    .input_frame  (input_frame),
    .output_frame (output_frame)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (DONE) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full frame: pulse START, measure latency, check result and pulse count.
  task automatic run_frame(input string tag, input logic [1:0] m, input logic [1:0] g,
                           input logic [14:0] t, input logic [31:0] fin,
                           input logic [31:0] exp);
    int n;
    int d0;
    @(negedge CLK);
    mode = m; pre_gain = g; threshold = t; input_frame = fin; START = 1'b1;
    d0 = done_cnt;
    @(posedge CLK); #1;
    START = 1'b0;
    check({tag, "_busy"}, 64'(BUSY), 64'd1);
    n = 0;
    while (!DONE && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd3);
    check({tag, "_out"}, 64'(output_frame), 64'(exp));
    @(posedge CLK); #1;
    check({tag, "_done_low"}, 64'(DONE), 64'd0);
    check({tag, "_idle"}, 64'(BUSY), 64'd0);
    check({tag, "_pulses"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    RESET_N = 1'b0; START = 1'b0; mode = '0; pre_gain = '0;
    threshold = '0; input_frame = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_out", 64'(output_frame), 64'd0);
    @(negedge CLK); RESET_N = 1'b1;

    // channel 1 in the upper half, channel 0 in the lower half
    run_frame("hard",   2'd1, 2'd0, 15'h0FFF, {16'h9000, 16'h7000}, {16'hF001, 16'h0FFF});
    run_frame("gain",   2'd1, 2'd3, 15'h7FFF, {16'hE000, 16'h2000}, {16'h8001, 16'h7FFF});
    run_frame("soft",   2'd2, 2'd0, 15'h1000, {16'hD000, 16'h3000}, {16'hE800, 16'h1800});
    run_frame("soft_in",2'd2, 2'd0, 15'h1000, {16'hF800, 16'h0800}, {16'hF800, 16'h0800});
    run_frame("bypass", 2'd0, 2'd3, 15'h0100, {16'h8000, 16'h1234}, {16'h8000, 16'h1234});
    run_frame("rsvd",   2'd3, 2'd0, 15'h0000, {16'h8000, 16'h1234}, 32'h0);

    // isolation: change inputs right after the accepting edge
    @(negedge CLK);
    mode = 2'd1; pre_gain = 2'd0; threshold = 15'h0FFF;
    input_frame = {16'h9000, 16'h7000}; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; mode = 2'd0; input_frame = {16'h1111, 16'h2222};
    repeat (3) @(posedge CLK);
    #1;
    check("iso_done", 64'(DONE), 64'd1);
    check("iso_out", 64'(output_frame), 64'({16'hF001, 16'h0FFF}));
    repeat (2) @(posedge CLK);

    // START held high: acceptance every 4 cycles
    @(negedge CLK);
    mode = 2'd1; pre_gain = 2'd0; threshold = 15'h0FFF;
    input_frame = {16'h9000, 16'h7000}; START = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK); #1;
      check($sformatf("hold_done_%0d", k), 64'(DONE), 64'((k % 4) == 3));
    end
    START = 1'b0;
    repeat (3) @(posedge CLK);

    // extra START pulses during RUN/FIN are ignored
    @(negedge CLK);
    START = 1'b1;
    d0 = done_cnt;
    repeat (4) @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("ignore_pulses", 64'(done_cnt - d0), 64'd1);
    check("ignore_idle", 64'(BUSY), 64'd0);

    // reset one cycle into RUN aborts the frame
    @(negedge CLK);
    mode = 2'd0; input_frame = {16'hAAAA, 16'h5555}; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    d0 = done_cnt;
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    #1;
    check("abort_out", 64'(output_frame), 64'd0);
    check("abort_busy", 64'(BUSY), 64'd0);
    check("abort_done", 64'(DONE), 64'd0);
    @(negedge CLK); RESET_N = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check("abort_no_pulse", 64'(done_cnt - d0), 64'd0);
    check("abort_out_held", 64'(output_frame), 64'd0);
    run_frame("post_rst", 2'd2, 2'd0, 15'h1000, {16'hD000, 16'h3000}, {16'hE800, 16'h1800});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
